hold_queue: RTL
===============

// Module: hold_queue
// PURPOSE
//   Parametrised multi-entry pipeline hold buffer; successor to the single-entry hold stage.
//   Sits between pipeline stages: zero-latency passthrough when empty and not stalled,
//   otherwise absorbs up to DEPTH words in FIFO order while downstream stalls.
//   Adds upstream backpressure (input_ready), occupancy, overflow flag and synchronous flush.
// PARAMETERS
//   WIDTH  1  data word width in bits
//   DEPTH  2  storage entries (>=1, need not be a power of two); DEPTH=1 acts as the legacy hold stage
// PORTS
//   clk          in   1                   clock, all state updates on posedge
//   reset_n      in   1                   asynchronous reset, active low
//   flush        in   1                   synchronous pipeline flush
//   data_in      in   WIDTH               upstream data
//   input_valid  in   1                   data_in valid this cycle
//   input_ready  out  1                   buffer can accept data_in this cycle
//   stall        in   1                   downstream cannot consume this cycle
//   data_out     out  WIDTH               data presented downstream
//   valid_out    out  1                   data_out valid; consumed when valid_out is high (stall implies no consume)
//   count        out  $clog2(DEPTH+1)     stored entries, 0..DEPTH
//   overflow     out  1                   one-cycle pulse: word dropped on full buffer
// BEHAVIOUR
//   Reset (reset_n=0, async): count=0, rd_ptr=wr_ptr=0, storage=0, overflow=0; valid_out=0,
//     input_ready=0, data_out=0 while reset_n low. Leaves reset on the first posedge after release.
//   empty = (count==0); full = (count==DEPTH).
//   passthrough = empty && input_valid && !stall && !flush; data_out = passthrough ? data_in : mem[rd_ptr].
//   valid_out   = reset_n && !stall && !flush && (!empty || input_valid).
//   input_ready = reset_n && !flush && (!full || !stall).
//   pop  = valid_out && !empty (head consumed, rd_ptr advances).
//   push = input_valid && !passthrough && !flush && (!full || pop).
//   Drop: input_valid && full && !pop && !flush -> word discarded, overflow=1 next cycle, state unchanged.
//   Passthrough: word leaves combinationally the same cycle; never written, count unchanged.
//   FIFO order strict: stored words always drain before any newer word; no passthrough unless empty.
//   Simultaneous push+pop (incl. at full): count unchanged, both pointers advance.
//   Pointers wrap DEPTH-1 -> 0 (explicit compare, not power-of-two masking).
//   count next = count + push - pop; never exceeds DEPTH, never underflows.
//   Flush (sync): next cycle count=0, rd_ptr=wr_ptr=0; input and head discarded this cycle;
//     valid_out=0 combinationally in flush cycle; storage contents not cleared. Flush overrides push/pop/drop.
//   Reset mid-operation: all buffered words lost immediately; no output pulse.
//   Latency: 0 cycles when empty and unstalled; otherwise a word leaves in the first unstalled cycle
//     after all older words have left.
// TESTING
//   1. WIDTH=8,DEPTH=4; stall=0, stream 0x11,0x22,0x33 -> data_out equals data_in same cycle, count stays 0.
//   2. stall=1, push 0xA1..0xA4 -> count=4, input_ready=0; drop stall -> 0xA1,0xA2,0xA3,0xA4 on 4 consecutive cycles.
//   3. full, stall=1, input_valid=1 data 0xEE -> overflow pulses 1 cycle, count=4, 0xEE never appears.
//   4. full, stall=0, input_valid=1 each cycle for 10 cycles -> count stays 4, pointers wrap, strict order kept.
//   5. count=3, assert flush with input_valid=1 -> valid_out=0 that cycle, count=0 next; new word then passes through.
//   6. count=2, pulse reset_n low between clock edges -> valid_out=0, count=0 immediately; DEPTH=3 repeat 2 for wrap.

Source files
------------

// File: rtl/hold_queue_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hold_queue_if : handshake/data bundle for the hold_queue buffer        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface hold_queue_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic               flush;
  logic [WIDTH-1:0]   data_in;
  logic               input_valid;
  logic               input_ready;
  logic               stall;
  logic [WIDTH-1:0]   data_out;
  logic               valid_out;
  logic [c_CNT_W-1:0] count;
  logic               overflow;

  modport master (
    output flush, data_in, input_valid, stall,
    input  input_ready, data_out, valid_out, count, overflow
  );

  modport slave (
    input  flush, data_in, input_valid, stall,
    output input_ready, data_out, valid_out, count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/hold_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hold_queue : multi-entry pipeline hold buffer with zero-latency        |
// |              passthrough, backpressure, overflow flag and flush        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module hold_queue #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  hold_queue_if.slave  bus
);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;

  logic w_empty, w_full, w_pass, w_valid, w_pop, w_push, w_drop;

  // Depth need not be a power of two, so wrap on an explicit compare
  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == c_FULL);
    w_pass  = w_empty && bus.input_valid && !bus.stall && !bus.flush;
    w_valid = reset_n && !bus.stall && !bus.flush && (!w_empty || bus.input_valid);
    w_pop   = w_valid && !w_empty;
    w_push  = bus.input_valid && !w_pass && !bus.flush && (!w_full || w_pop);
    w_drop  = bus.input_valid && w_full && !w_pop && !bus.flush;
  end

  assign bus.valid_out   = w_valid;
  assign bus.input_ready = reset_n && !bus.flush && (!w_full || !bus.stall);
  assign bus.data_out    = !reset_n ? '0 : (w_pass ? bus.data_in : r_mem[r_rd_ptr]);
  assign bus.count       = r_count;
  assign bus.overflow    = r_overflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_overflow <= w_drop;
      if (bus.flush) begin
        // Storage is left as-is; only the bookkeeping is cleared
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= bus.data_in;
          r_wr_ptr        <= f_next(r_wr_ptr);
        end
        if (w_pop) begin
          r_rd_ptr <= f_next(r_rd_ptr);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end
endmodule
`default_nettype wire
